// File: rtl/fdiv_sched.sv
// Run-time controller for the lab clock divider: owns the active divisor,
// starts/stops the divided clock and swaps divisors only on period boundaries.
module fdiv_sched #(
   parameter int W           = 32,
   parameter int DIV_DEFAULT = 4,
   parameter int PCNT_W      = 16
) (
   input  logic              fin,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              cfg_valid,
   input  logic [W-1:0]      cfg_div,
   output logic              cfg_ready,
   output logic              cfg_err,
   output logic              fout,
   output logic              tick,
   output logic              running,
   output logic [W-1:0]      div_act,
   output logic [PCNT_W-1:0] periods
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t              state_reg;
   logic [W-1:0]        cnt_reg;
   logic [W-1:0]        div_act_reg;
   logic [W-1:0]        div_pend_reg;
   logic                pend_v_reg;
   logic                fout_reg;
   logic                tick_reg;
   logic                cfg_err_reg;
   logic [PCNT_W-1:0]   periods_reg;

   logic                accept;
   logic                div_ok;
   logic                wrap;
   logic [W-1:0]        half_div;

   assign cfg_ready = !pend_v_reg && (state_reg != DRAIN);
   assign accept    = cfg_valid && cfg_ready;
   assign div_ok    = (cfg_div >= W'(2));
   assign wrap      = (cnt_reg == div_act_reg);
   assign half_div  = div_act_reg >> 1;

   assign running = (state_reg != IDLE);
   assign cfg_err = cfg_err_reg;
   assign fout    = fout_reg;
   assign tick    = tick_reg;
   assign div_act = div_act_reg;
   assign periods = periods_reg;

   always_ff @(posedge fin or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         div_act_reg  <= W'(DIV_DEFAULT);
         div_pend_reg <= '0;
         pend_v_reg   <= 1'b0;
         fout_reg     <= 1'b0;
         tick_reg     <= 1'b0;
         cfg_err_reg  <= 1'b0;
         periods_reg  <= '0;
      end else begin
         tick_reg <= 1'b0;
         if (accept)
            cfg_err_reg <= !div_ok;

         case (state_reg)
            IDLE: begin
               cnt_reg  <= '0;
               fout_reg <= 1'b0;
               if (accept && div_ok)
                  div_act_reg <= cfg_div;
               // stop has priority over a simultaneous start
               if (start && !stop) begin
                  state_reg   <= RUN;
                  cnt_reg     <= W'(1);
                  periods_reg <= '0;
               end
            end
            default: begin
               cnt_reg  <= wrap ? W'(1) : cnt_reg + W'(1);
               fout_reg <= (cnt_reg > half_div);
               tick_reg <= wrap;
               if (wrap && (periods_reg != {PCNT_W{1'b1}}))
                  periods_reg <= periods_reg + PCNT_W'(1);
               // wrap compare above used the old divisor; the new one starts at cnt=1
               if (wrap && pend_v_reg) begin
                  div_act_reg <= div_pend_reg;
                  pend_v_reg  <= 1'b0;
               end
               if ((state_reg == RUN) && accept && div_ok) begin
                  div_pend_reg <= cfg_div;
                  pend_v_reg   <= 1'b1;
               end
               if ((state_reg == RUN) && stop)
                  state_reg <= DRAIN;
               if ((state_reg == DRAIN) && wrap) begin
                  state_reg <= IDLE;
                  cnt_reg   <= '0;
                  fout_reg  <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fdiv_sched.sv
// Directed plus randomized bench for fdiv_sched, checked against a
// period-position reference model.
module tb_fdiv_sched;

   localparam int W      = 32;
   localparam int PCNT_W = 8;

   logic              fin = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic              cfg_valid = 1'b0;
   logic [W-1:0]      cfg_div = '0;
   logic              cfg_ready;
   logic              cfg_err;
   logic              fout;
   logic              tick;
   logic              running;
   logic [W-1:0]      div_act;
   logic [PCNT_W-1:0] periods;

   int checks = 0;
   int errors = 0;

   // reference model: mode 0 idle, 1 run, 2 draining; ph = 0-based position in period
   int      m_mode;
   int      m_ph;
   longint  m_div;
   longint  m_pend;
   bit      m_pend_v;
   bit      m_fout;
   bit      m_tick;
   bit      m_err;
   int      m_periods;
   int      max_periods;

   fdiv_sched #(.W(W), .DIV_DEFAULT(4), .PCNT_W(PCNT_W)) dut (
      .fin(fin), .reset(reset), .start(start), .stop(stop),
      .cfg_valid(cfg_valid), .cfg_div(cfg_div), .cfg_ready(cfg_ready),
      .cfg_err(cfg_err), .fout(fout), .tick(tick), .running(running),
      .div_act(div_act), .periods(periods)
   );

   always #5 fin = ~fin;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_ph = 0; m_div = 4; m_pend = 0; m_pend_v = 0;
      m_fout = 0; m_tick = 0; m_err = 0; m_periods = 0;
   endtask

   function automatic bit m_ready();
      return !m_pend_v && (m_mode != 2);
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".fout"},    W'(fout),      W'(m_fout));
      chk({tag, ".tick"},    W'(tick),      W'(m_tick));
      chk({tag, ".running"}, W'(running),   W'(m_mode != 0));
      chk({tag, ".div_act"}, div_act,       W'(m_div));
      chk({tag, ".periods"}, W'(periods),   W'(m_periods));
      chk({tag, ".ready"},   W'(cfg_ready), W'(m_ready()));
      chk({tag, ".err"},     W'(cfg_err),   W'(m_err));
   endtask

   // one clock: drive inputs, advance model, compare after the edge
   task automatic step(input string tag, input bit s, input bit st, input bit cv,
                       input logic [W-1:0] cd);
      bit acc, last, ok;
      int mode0;
      start = s; stop = st; cfg_valid = cv; cfg_div = cd;
      acc   = cv && m_ready();
      ok    = (cd >= 2);
      mode0 = m_mode;
      if (acc) m_err = !ok;
      if (mode0 == 0) begin
         m_fout = 0; m_tick = 0;
         if (acc && ok) m_div = cd;
         if (s && !st) begin m_mode = 1; m_ph = 0; m_periods = 0; end
      end else begin
         last   = (m_ph == m_div - 1);
         m_fout = (m_ph + 1) > (m_div / 2);
         m_tick = last;
         m_ph   = last ? 0 : m_ph + 1;
         if (last && m_periods < max_periods) m_periods++;
         if (last && m_pend_v) begin m_div = m_pend; m_pend_v = 0; end
         if (mode0 == 1 && acc && ok) begin m_pend = cd; m_pend_v = 1; end
         if (mode0 == 1 && st) m_mode = 2;
         if (mode0 == 2 && last) begin m_mode = 0; m_fout = 0; end
      end
      @(posedge fin);
      #1;
      check_all(tag);
   endtask

   task automatic idle_steps(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 0, 0, 0, '0);
   endtask

   task automatic align_period(input string tag);
      for (int i = 0; i < 1000 && m_ph != 0; i++) step(tag, 0, 0, 0, '0);
      chk({tag, ".align"}, W'(m_ph), W'(0));
   endtask

   task automatic async_reset(input string tag);
      @(posedge fin);
      #3 reset = 1'b0;
      #1;
      model_reset();
      chk({tag, ".fout"},    W'(fout),    W'(0));
      chk({tag, ".running"}, W'(running), W'(0));
      chk({tag, ".div_act"}, div_act,     W'(4));
      chk({tag, ".periods"}, W'(periods), W'(0));
      chk({tag, ".tick"},    W'(tick),    W'(0));
      @(posedge fin);
      #2 reset = 1'b1;
   endtask

   initial begin
      max_periods = (1 << PCNT_W) - 1;
      model_reset();
      @(posedge fin); @(posedge fin); #1;
      check_all("reset");
      #2 reset = 1'b1;

      // basic run at DIV=4
      step("t1_start", 1, 0, 0, '0);
      idle_steps("t1_run", 12);
      // reprogram to 6 while cnt=2
      step("t2_pre", 0, 0, 0, '0);
      step("t2_cfg", 0, 0, 1, 32'd6);
      idle_steps("t2_run", 16);
      // bad divisor then odd divisor
      step("t3_bad", 0, 0, 1, 32'd1);
      idle_steps("t3_a", 3);
      step("t3_five", 0, 0, 1, 32'd5);
      idle_steps("t3_b", 15);
      // stop at cnt=1 after going back to 4
      step("t4_cfg", 0, 0, 1, 32'd4);
      idle_steps("t4_a", 6);
      align_period("t4_align");
      step("t4_stop", 0, 1, 0, '0);
      idle_steps("t4_drain", 6);
      step("t4_both", 1, 1, 0, '0);
      idle_steps("t4_idle", 3);
      // async reset mid-period at DIV=434, cnt=200
      step("t5_cfg", 0, 0, 1, 32'd434);
      step("t5_start", 1, 0, 0, '0);
      idle_steps("t5_run", 199);
      async_reset("t5_rst");
      step("t5_restart", 1, 0, 0, '0);
      idle_steps("t5_clean", 10);
      step("t5_stop", 0, 1, 0, '0);
      idle_steps("t5_drain", 6);
      // DIV=2 toggle and period-counter saturation
      step("t6_cfg", 0, 0, 1, 32'd2);
      step("t6_start", 1, 0, 0, '0);
      idle_steps("t6_run", 2 * (max_periods + 5));
      chk("t6_sat", W'(periods), W'(max_periods));
      step("t6_stop", 0, 1, 0, '0);
      idle_steps("t6_drain", 3);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bit s, st, cv;
         logic [W-1:0] cd;
         if ($urandom_range(0, 499) == 0) async_reset("rnd_rst");
         s  = ($urandom_range(0, 19) == 0);
         st = ($urandom_range(0, 39) == 0);
         cv = ($urandom_range(0, 9) == 0);
         cd = W'($urandom_range(0, 9));
         step("rnd", s, st, cv, cd);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
